// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory read, results buffered in a 2-entry {inst, pc} FIFO.
// Redirects flush the FIFO and retarget the PC; data returned for a stale request is dropped.
module fetch_unit #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk_id,
  input  logic            n_reset,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] inst_pc
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_mem_req;
  logic            w_mem_req_nxt;
  logic [PC_W-1:0] r_mem_addr;
  logic [PC_W-1:0] w_mem_addr_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic            w_push;
  logic            w_pop;

  logic [31:0]     r_fifo_inst [2];
  logic [PC_W-1:0] r_fifo_pc   [2];
  logic            r_wptr;
  logic            r_rptr;
  logic [1:0]      r_count;

  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign inst_valid = (r_count != 2'd0);
  assign inst       = r_fifo_inst[r_rptr];
  assign inst_pc    = r_fifo_pc[r_rptr];
  // A redirect flushes the FIFO, so it wins over a same-cycle pop
  assign w_pop      = inst_valid && inst_ready && !redirect;

  always_ff @(posedge clk_id or negedge n_reset) begin
    if (!n_reset) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_pc       <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_pc       <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_mem_req_nxt  = r_mem_req;
    w_mem_addr_nxt = r_mem_addr;
    w_pc_nxt       = r_pc;
    w_push         = 1'b0;
    if (redirect) w_pc_nxt = redirect_pc;
    case (r_state)
      S_IDLE: begin
        // Only request when the FIFO can take the result: no push into a full FIFO
        if (!redirect && r_count != 2'd2) begin
          w_state_nxt    = S_WAIT;
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = r_pc;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          w_state_nxt   = S_IDLE;
          w_mem_req_nxt = 1'b0;
          if (!redirect) begin
            w_push   = 1'b1;
            w_pc_nxt = r_pc + PC_W'(1);
          end
        end else if (redirect) begin
          w_state_nxt = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (mem_ack) begin
          w_state_nxt   = S_IDLE;
          w_mem_req_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_id or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < 2; i++) begin
        r_fifo_inst[i] <= '0;
        r_fifo_pc[i]   <= '0;
      end
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else if (redirect) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_inst[r_wptr] <= mem_rdata;
        r_fifo_pc[r_wptr]   <= r_mem_addr;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, backpressure, redirects, PC wrap, mid-flight reset.
module tb_fetch_unit;

  logic        clk_id = 1'b0;
  logic        n_reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [15:0] inst_pc;

  int n_asserts = 0;
  int n_fail    = 0;

  fetch_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk_id      (clk_id),
    .n_reset     (n_reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc)
  );

  always #5 clk_id = ~clk_id;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory contents: distinct, recognisable word per address
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {16'hC0DE, a ^ 16'h5A5A};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_id);
    #1;
  endtask

  initial begin
    n_reset = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_req",   32'(mem_req),    32'h0);
    chk("rst_addr",  32'(mem_addr),   32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst",  inst,            32'h0);
    chk("rst_pc",    32'(inst_pc),    32'h0);
    tick;
    n_reset = 1'b1;
    tick;
    chk("first_req",  32'(mem_req),  32'h1);
    chk("first_addr", 32'(mem_addr), 32'h0);

    // Sequential fetch, ack one cycle after each request, decoder always ready
    inst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("seq_req",  32'(mem_req),  32'h1);
      chk("seq_addr", 32'(mem_addr), 32'(k));
      mem_ack = 1'b1; mem_rdata = mem_word(16'(k));
      tick;
      mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
      chk("seq_valid", 32'(inst_valid), 32'h1);
      chk("seq_pc",    32'(inst_pc),    32'(k));
      chk("seq_inst",  inst,            mem_word(16'(k)));
      chk("seq_req0",  32'(mem_req),    32'h0);
      tick;
    end

    // Backpressure: decoder stalled, FIFO fills to 2 and fetch stops
    inst_ready = 1'b0;
    n_reset = 1'b0;
    #1;
    n_reset = 1'b1;
    tick;
    chk("bp_first_addr", 32'(mem_addr), 32'h0);
    for (int i = 0; i < 10; i++) begin
      mem_ack = mem_req; mem_rdata = mem_word(mem_addr);
      tick;
      mem_ack = 1'b0;
      chk("bp_hold_pc",   32'(inst_pc), 32'h0);
      chk("bp_hold_inst", inst,         mem_word(16'h0000));
    end
    chk("bp_req_off", 32'(mem_req),    32'h0);
    chk("bp_valid",   32'(inst_valid), 32'h1);
    // Stray ack with no request outstanding must not push
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick;
    mem_ack = 1'b0;
    inst_ready = 1'b1;
    tick;
    chk("bp_pop1_valid", 32'(inst_valid), 32'h1);
    chk("bp_pop1_pc",    32'(inst_pc),    32'h1);
    chk("bp_pop1_inst",  inst,            mem_word(16'h0001));
    tick;
    chk("bp_empty",    32'(inst_valid), 32'h0);
    chk("bp_next_req", 32'(mem_req),    32'h1);
    chk("bp_next_addr",32'(mem_addr),   32'h2);

    // Redirect while WAIT, ack delayed: returned word dropped
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick;
    redirect = 1'b0;
    chk("rd_req_held",  32'(mem_req),    32'h1);
    chk("rd_addr_held", 32'(mem_addr),   32'h2);
    chk("rd_valid0",    32'(inst_valid), 32'h0);
    tick;
    tick;
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick;
    mem_ack = 1'b0;
    chk("rd_drop_valid", 32'(inst_valid), 32'h0);
    chk("rd_drop_req",   32'(mem_req),    32'h0);
    tick;
    chk("rd_new_req",  32'(mem_req),    32'h1);
    chk("rd_new_addr", 32'(mem_addr),   32'h40);
    chk("rd_valid_w",  32'(inst_valid), 32'h0);
    tick;
    chk("rd_valid_w2", 32'(inst_valid), 32'h0);
    mem_ack = 1'b1; mem_rdata = mem_word(16'h0040);
    tick;
    mem_ack = 1'b0;
    chk("rd_got_valid", 32'(inst_valid), 32'h1);
    chk("rd_got_pc",    32'(inst_pc),    32'h40);
    chk("rd_got_inst",  inst,            mem_word(16'h0040));

    // Redirect together with mem_ack and a pop
    inst_ready = 1'b0;
    tick;
    chk("rp_valid", 32'(inst_valid), 32'h1);
    chk("rp_addr",  32'(mem_addr),   32'h41);
    inst_ready = 1'b1;
    mem_ack = 1'b1; mem_rdata = mem_word(16'h0041);
    redirect = 1'b1; redirect_pc = 16'h0123;
    tick;
    mem_ack = 1'b0; redirect = 1'b0;
    chk("rp_flush", 32'(inst_valid), 32'h0);
    chk("rp_req0",  32'(mem_req),    32'h0);
    tick;
    chk("rp_req",   32'(mem_req),    32'h1);
    chk("rp_addr2", 32'(mem_addr),   32'h123);
    chk("rp_nopush",32'(inst_valid), 32'h0);

    // PC wrap at 0xFFFF
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    tick;
    redirect = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hBAD1_BAD1;
    tick;
    mem_ack = 1'b0;
    tick;
    chk("wr_addr_ffff", 32'(mem_addr), 32'hFFFF);
    inst_ready = 1'b0;
    mem_ack = 1'b1; mem_rdata = mem_word(16'hFFFF);
    tick;
    mem_ack = 1'b0;
    chk("wr_pc_ffff",   32'(inst_pc), 32'hFFFF);
    chk("wr_inst_ffff", inst,         mem_word(16'hFFFF));
    inst_ready = 1'b1;
    tick;
    chk("wr_req_0000",  32'(mem_req),  32'h1);
    chk("wr_addr_0000", 32'(mem_addr), 32'h0);
    mem_ack = 1'b1; mem_rdata = mem_word(16'h0000);
    tick;
    mem_ack = 1'b0;
    chk("wr_pc_0000",   32'(inst_pc), 32'h0);
    chk("wr_inst_0000", inst,         mem_word(16'h0000));

    // Reset pulse while WAIT, then a stray ack
    tick;
    chk("mr_wait_req",  32'(mem_req),  32'h1);
    chk("mr_wait_addr", 32'(mem_addr), 32'h1);
    n_reset = 1'b0;
    #1;
    chk("mr_req",   32'(mem_req),    32'h0);
    chk("mr_addr",  32'(mem_addr),   32'h0);
    chk("mr_valid", 32'(inst_valid), 32'h0);
    chk("mr_inst",  inst,            32'h0);
    chk("mr_pc",    32'(inst_pc),    32'h0);
    #1;
    n_reset = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hBAD2_BAD2;
    tick;
    mem_ack = 1'b0;
    chk("mr_stray_valid", 32'(inst_valid), 32'h0);
    chk("mr_stray_inst",  inst,            32'h0);
    chk("mr_first_req",   32'(mem_req),    32'h1);
    chk("mr_first_addr",  32'(mem_addr),   32'h0);
    mem_ack = 1'b1; mem_rdata = mem_word(16'h0000);
    tick;
    mem_ack = 1'b0;
    chk("mr_got_pc",   32'(inst_pc), 32'h0);
    chk("mr_got_inst", inst,         mem_word(16'h0000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
